i2c_target_receiver: RTL and testbench

//  Write-only I2C target (slave) for the lab3 codec-config path: the bus-side counterpart of the
//  I2C configuration initiator. Oversamples SCL/SDA on the system clock and decodes START/STOP.

---
 rtl/i2c_target_receiver.sv | 203 ++++++++++++++++++++
 tb/tb_i2c_target_receiver.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_receiver.sv
// Write-only I2C target. Oversamples SCL/SDA on the system clock, decodes START/STOP,
// matches a 7-bit address, ACKs every byte of a matched write and strobes out each
// received data byte together with its index in the transaction.
module i2c_target_receiver #(
  parameter logic [6:0] TARGET_ADDR = 7'h1A
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_sda_oen,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic [3:0] o_byte_idx,
  output logic       o_busy,
  output logic       o_stop
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_DATA,
    S_DATA_ACK,
    S_IGNORE
  } state_t;

  logic   scl_meta_q, scl_meta_d, scl_sync_q, scl_sync_d, scl_prev_q, scl_prev_d;
  logic   sda_meta_q, sda_meta_d, sda_sync_q, sda_sync_d, sda_prev_q, sda_prev_d;
  state_t state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       byte_done_q, byte_done_d;
  logic       match_q, match_d;
  logic       sda_oen_q, sda_oen_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic [3:0] byte_idx_q, byte_idx_d;
  logic       busy_q, busy_d;
  logic       stop_q, stop_d;

  logic       start_ev, stop_ev, scl_rise, scl_fall;
  logic [7:0] shifted;

  // Two-stage synchronizer per line plus one delayed copy for edge detection
  always_comb begin
    scl_meta_d = i_scl;
    scl_sync_d = scl_meta_q;
    scl_prev_d = scl_sync_q;
    sda_meta_d = i_sda;
    sda_sync_d = sda_meta_q;
    sda_prev_d = sda_sync_q;
  end

  // Bus events; START/STOP need SCL high on both samples so an SCL edge never looks like one
  always_comb begin
    start_ev = scl_sync_q & scl_prev_q & sda_prev_q & ~sda_sync_q;
    stop_ev  = scl_sync_q & scl_prev_q & ~sda_prev_q & sda_sync_q;
    scl_rise = scl_sync_q & ~scl_prev_q;
    scl_fall = ~scl_sync_q & scl_prev_q;
    shifted  = {shift_q[6:0], sda_sync_q};
  end

  // Protocol FSM: START/STOP override everything, otherwise act on SCL edges per state
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    byte_done_d = byte_done_q;
    match_d     = match_q;
    sda_oen_d   = sda_oen_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    byte_idx_d  = byte_idx_q;
    busy_d      = busy_q;
    stop_d      = 1'b0;
    if (stop_ev) begin
      state_d     = S_IDLE;
      sda_oen_d   = 1'b0;
      busy_d      = 1'b0;
      stop_d      = busy_q;
      bit_cnt_d   = 3'd0;
      byte_done_d = 1'b0;
    end else if (start_ev) begin
      state_d     = S_ADDR;
      sda_oen_d   = 1'b0;
      bit_cnt_d   = 3'd0;
      byte_done_d = 1'b0;
    end else begin
      case (state_q)
        S_ADDR: begin
          if (scl_rise && !byte_done_q) begin
            shift_d   = shifted;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              byte_done_d = 1'b1;
              match_d     = (shifted[7:1] == TARGET_ADDR) && !shifted[0];
            end
          end else if (scl_fall && byte_done_q) begin
            byte_done_d = 1'b0;
            bit_cnt_d   = 3'd0;
            if (match_q) begin
              state_d    = S_ADDR_ACK;
              sda_oen_d  = 1'b1;
              busy_d     = 1'b1;
              byte_idx_d = 4'd0;
            end else begin
              state_d = S_IGNORE;
              busy_d  = 1'b0;
            end
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall) begin
            state_d   = S_DATA;
            sda_oen_d = 1'b0;
          end
        end
        S_DATA: begin
          if (scl_rise && !byte_done_q) begin
            shift_d   = shifted;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              byte_done_d = 1'b1;
              data_d      = shifted;
              valid_d     = 1'b1;
            end
          end else if (scl_fall && byte_done_q) begin
            byte_done_d = 1'b0;
            bit_cnt_d   = 3'd0;
            state_d     = S_DATA_ACK;
            sda_oen_d   = 1'b1;
          end
        end
        S_DATA_ACK: begin
          if (scl_fall) begin
            state_d   = S_DATA;
            sda_oen_d = 1'b0;
            if (byte_idx_q != 4'd15) begin
              byte_idx_d = byte_idx_q + 4'd1;
            end
          end
        end
        S_IGNORE: begin
          sda_oen_d = 1'b0;
          busy_d    = 1'b0;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and output registers; synchronizers reset to the idle-bus level
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      scl_meta_q  <= 1'b1;
      scl_sync_q  <= 1'b1;
      scl_prev_q  <= 1'b1;
      sda_meta_q  <= 1'b1;
      sda_sync_q  <= 1'b1;
      sda_prev_q  <= 1'b1;
      state_q     <= S_IDLE;
      shift_q     <= 8'd0;
      bit_cnt_q   <= 3'd0;
      byte_done_q <= 1'b0;
      match_q     <= 1'b0;
      sda_oen_q   <= 1'b0;
      data_q      <= 8'd0;
      valid_q     <= 1'b0;
      byte_idx_q  <= 4'd0;
      busy_q      <= 1'b0;
      stop_q      <= 1'b0;
    end else begin
      scl_meta_q  <= scl_meta_d;
      scl_sync_q  <= scl_sync_d;
      scl_prev_q  <= scl_prev_d;
      sda_meta_q  <= sda_meta_d;
      sda_sync_q  <= sda_sync_d;
      sda_prev_q  <= sda_prev_d;
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_done_q <= byte_done_d;
      match_q     <= match_d;
      sda_oen_q   <= sda_oen_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      byte_idx_q  <= byte_idx_d;
      busy_q      <= busy_d;
      stop_q      <= stop_d;
    end
  end

  assign o_sda_oen  = sda_oen_q;
  assign o_data     = data_q;
  assign o_valid    = valid_q;
  assign o_byte_idx = byte_idx_q;
  assign o_busy     = busy_q;
  assign o_stop     = stop_q;

endmodule

// File: tb/tb_i2c_target_receiver.sv
// Bench for the write-only I2C target: an initiator drives SCL/SDA on a wired-AND bus,
// a monitor records strobes, and a transaction-level model predicts ACKs and data.
module tb_i2c_target_receiver;

  localparam int Q = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       init_scl = 1'b1;
  logic       init_sda = 1'b1;
  logic       bus_sda;
  logic       sda_oen;
  logic [7:0] data;
  logic       valid;
  logic [3:0] byte_idx;
  logic       busy;
  logic       stop;

  int checks = 0;
  int errors = 0;

  logic [7:0] obs_data_q[$];
  logic [3:0] obs_idx_q[$];
  int stop_cnt = 0;
  int busy_cyc = 0;
  int oen_cyc = 0;

  logic [7:0] tx_q[$];
  logic       ack_q[$];
  logic       exp_ack_q[$];
  logic [7:0] exp_data_q[$];
  logic [3:0] exp_idx_q[$];
  int         exp_stop;

  assign bus_sda = init_sda & ~sda_oen;

  i2c_target_receiver dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_scl      (init_scl),
    .i_sda      (bus_sda),
    .o_sda_oen  (sda_oen),
    .o_data     (data),
    .o_valid    (valid),
    .o_byte_idx (byte_idx),
    .o_busy     (busy),
    .o_stop     (stop)
  );

  always #5 clk = ~clk;

  // Monitor samples the outputs on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (valid) begin
      obs_data_q.push_back(data);
      obs_idx_q.push_back(byte_idx);
    end
    if (stop) stop_cnt++;
    if (busy) busy_cyc++;
    if (sda_oen) oen_cyc++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic v, output logic seen);
    wait_clk(Q);
    init_sda = v;
    wait_clk(Q);
    init_scl = 1'b1;
    wait_clk(Q);
    seen = bus_sda;
    wait_clk(Q);
    init_scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic seen;
    for (int i = 7; i >= 0; i--) send_bit(b[i], seen);
    send_bit(1'b1, seen);
    ack = (seen == 1'b0);
  endtask

  task automatic do_start();
    if (init_scl == 1'b0) begin
      wait_clk(Q);
      init_sda = 1'b1;
      wait_clk(Q);
      init_scl = 1'b1;
    end
    wait_clk(Q);
    init_sda = 1'b0;
    wait_clk(Q);
    init_scl = 1'b0;
  endtask

  task automatic do_stop();
    wait_clk(Q);
    init_sda = 1'b0;
    wait_clk(Q);
    init_scl = 1'b1;
    wait_clk(Q);
    init_sda = 1'b1;
    wait_clk(2 * Q);
  endtask

  // Full write transaction: START, address byte, every byte of tx_q, STOP
  task automatic drive_txn(input logic [7:0] addr);
    logic a;
    ack_q.delete();
    do_start();
    send_byte(addr, a);
    ack_q.push_back(a);
    foreach (tx_q[k]) begin
      send_byte(tx_q[k], a);
      ack_q.push_back(a);
    end
    do_stop();
  endtask

  // Reference model: a write to 0x34 is fully ACKed and yields one strobe per byte
  task automatic model_txn(input logic [7:0] addr);
    logic hit;
    hit = (addr == 8'h34);
    exp_ack_q.delete();
    exp_data_q.delete();
    exp_idx_q.delete();
    exp_ack_q.push_back(hit);
    foreach (tx_q[k]) begin
      exp_ack_q.push_back(hit);
      if (hit) begin
        exp_data_q.push_back(tx_q[k]);
        exp_idx_q.push_back((k > 15) ? 4'd15 : 4'(k));
      end
    end
    exp_stop = hit ? 1 : 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    init_scl = 1'b1;
    init_sda = 1'b1;
    wait_clk(3);
    @(negedge clk);
    checks++; if (sda_oen !== 1'b0) begin errors++; $display("[TB] FAIL reset_oen got %b want 0", sda_oen); end
    checks++; if (data !== 8'h00) begin errors++; $display("[TB] FAIL reset_data got %h want 00", data); end
    checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", valid); end
    checks++; if (byte_idx !== 4'd0) begin errors++; $display("[TB] FAIL reset_idx got %0d want 0", byte_idx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    checks++; if (stop !== 1'b0) begin errors++; $display("[TB] FAIL reset_stop got %b want 0", stop); end
    rst_n = 1'b1;
    wait_clk(4);
  endtask

  task automatic test_write();
    int base, sbase, bbase, n;
    tx_q = '{8'h1E, 8'h00};
    model_txn(8'h34);
    base = obs_data_q.size(); sbase = stop_cnt; bbase = busy_cyc;
    drive_txn(8'h34);
    foreach (exp_ack_q[k]) begin
      checks++; if (ack_q[k] !== exp_ack_q[k]) begin errors++; $display("[TB] FAIL t1_ack[%0d] got %b want %b", k, ack_q[k], exp_ack_q[k]); end
    end
    n = obs_data_q.size() - base;
    checks++; if (n != exp_data_q.size()) begin errors++; $display("[TB] FAIL t1_nvalid got %0d want %0d", n, exp_data_q.size()); end
    for (int k = 0; k < n && k < exp_data_q.size(); k++) begin
      checks++;
      if (obs_data_q[base+k] !== exp_data_q[k] || obs_idx_q[base+k] !== exp_idx_q[k]) begin
        errors++; $display("[TB] FAIL t1_byte[%0d] got %h/%0d want %h/%0d", k, obs_data_q[base+k], obs_idx_q[base+k], exp_data_q[k], exp_idx_q[k]);
      end
    end
    checks++; if (stop_cnt - sbase != exp_stop) begin errors++; $display("[TB] FAIL t1_stop got %0d want %0d", stop_cnt - sbase, exp_stop); end
    checks++; if (busy_cyc == bbase) begin errors++; $display("[TB] FAIL t1_busy_seen got 0 want 1"); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL t1_busy_after got %b want 0", busy); end
  endtask

  task automatic test_wrong_addr();
    int base, sbase, bbase, obase;
    tx_q = '{8'hAA};
    model_txn(8'h36);
    base = obs_data_q.size(); sbase = stop_cnt; bbase = busy_cyc; obase = oen_cyc;
    drive_txn(8'h36);
    foreach (exp_ack_q[k]) begin
      checks++; if (ack_q[k] !== exp_ack_q[k]) begin errors++; $display("[TB] FAIL t2_ack[%0d] got %b want %b", k, ack_q[k], exp_ack_q[k]); end
    end
    checks++; if (oen_cyc != obase) begin errors++; $display("[TB] FAIL t2_oen got %0d cycles want 0", oen_cyc - obase); end
    checks++; if (obs_data_q.size() != base) begin errors++; $display("[TB] FAIL t2_nvalid got %0d want 0", obs_data_q.size() - base); end
    checks++; if (stop_cnt != sbase) begin errors++; $display("[TB] FAIL t2_stop got %0d want 0", stop_cnt - sbase); end
    checks++; if (busy_cyc != bbase) begin errors++; $display("[TB] FAIL t2_busy got %0d cycles want 0", busy_cyc - bbase); end
  endtask

  task automatic test_read();
    int base, sbase, bbase;
    tx_q = '{8'($urandom_range(0, 255))};
    model_txn(8'h35);
    base = obs_data_q.size(); sbase = stop_cnt; bbase = busy_cyc;
    drive_txn(8'h35);
    foreach (exp_ack_q[k]) begin
      checks++; if (ack_q[k] !== exp_ack_q[k]) begin errors++; $display("[TB] FAIL t3_ack[%0d] got %b want %b", k, ack_q[k], exp_ack_q[k]); end
    end
    checks++; if (obs_data_q.size() != base) begin errors++; $display("[TB] FAIL t3_nvalid got %0d want 0", obs_data_q.size() - base); end
    checks++; if (stop_cnt != sbase) begin errors++; $display("[TB] FAIL t3_stop got %0d want 0", stop_cnt - sbase); end
    checks++; if (busy_cyc != bbase) begin errors++; $display("[TB] FAIL t3_busy got %0d cycles want 0", busy_cyc - bbase); end
  endtask

  task automatic test_repeated_start();
    int base, sbase, n;
    logic a, seen;
    logic acks[$];
    logic [7:0] want_d[$];
    want_d = '{8'h12, 8'h56};
    base = obs_data_q.size(); sbase = stop_cnt;
    do_start();
    send_byte(8'h34, a); acks.push_back(a);
    send_byte(8'h12, a); acks.push_back(a);
    for (int i = 0; i < 4; i++) send_bit(1'b1, seen);
    do_start();
    send_byte(8'h34, a); acks.push_back(a);
    send_byte(8'h56, a); acks.push_back(a);
    do_stop();
    foreach (acks[k]) begin
      checks++; if (acks[k] !== 1'b1) begin errors++; $display("[TB] FAIL t4_ack[%0d] got %b want 1", k, acks[k]); end
    end
    n = obs_data_q.size() - base;
    checks++; if (n != 2) begin errors++; $display("[TB] FAIL t4_nvalid got %0d want 2", n); end
    for (int k = 0; k < n && k < 2; k++) begin
      checks++;
      if (obs_data_q[base+k] !== want_d[k] || obs_idx_q[base+k] !== 4'd0) begin
        errors++; $display("[TB] FAIL t4_byte[%0d] got %h/%0d want %h/0", k, obs_data_q[base+k], obs_idx_q[base+k], want_d[k]);
      end
    end
    checks++; if (stop_cnt - sbase != 1) begin errors++; $display("[TB] FAIL t4_stop got %0d want 1", stop_cnt - sbase); end
  endtask

  task automatic test_reset_mid();
    int base, sbase, obase, n;
    logic a, seen;
    logic [7:0] b0;
    logic [7:0] want_d[$];
    logic [3:0] want_i[$];
    b0 = 8'($urandom_range(0, 255));
    base = obs_data_q.size(); sbase = stop_cnt;
    do_start();
    send_byte(8'h34, a);
    checks++; if (a !== 1'b1) begin errors++; $display("[TB] FAIL t5_addr_ack got %b want 1", a); end
    for (int i = 7; i >= 0; i--) send_bit(b0[i], seen);
    wait_clk(Q);
    checks++; if (sda_oen !== 1'b1) begin errors++; $display("[TB] FAIL t5_oen_before got %b want 1", sda_oen); end
    rst_n = 1'b0;
    wait_clk(1);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (sda_oen !== 1'b0) begin errors++; $display("[TB] FAIL t5_oen_after got %b want 0", sda_oen); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL t5_busy_after got %b want 0", busy); end
    obase = oen_cyc;
    wait_clk(1);
    init_sda = 1'b1;
    wait_clk(Q);
    init_scl = 1'b1;
    wait_clk(2 * Q);
    init_scl = 1'b0;
    for (int i = 0; i < 2; i++) begin
      send_byte(8'($urandom_range(0, 255)), a);
      checks++; if (a !== 1'b0) begin errors++; $display("[TB] FAIL t5_orphan_ack[%0d] got %b want 0", i, a); end
    end
    do_stop();
    checks++; if (oen_cyc != obase) begin errors++; $display("[TB] FAIL t5_orphan_oen got %0d cycles want 0", oen_cyc - obase); end
    checks++; if (stop_cnt != sbase) begin errors++; $display("[TB] FAIL t5_orphan_stop got %0d want 0", stop_cnt - sbase); end
    tx_q = '{8'h1E, 8'h00};
    model_txn(8'h34);
    drive_txn(8'h34);
    foreach (exp_ack_q[k]) begin
      checks++; if (ack_q[k] !== exp_ack_q[k]) begin errors++; $display("[TB] FAIL t5_ack[%0d] got %b want %b", k, ack_q[k], exp_ack_q[k]); end
    end
    want_d.push_back(b0); want_i.push_back(4'd0);
    foreach (exp_data_q[k]) begin want_d.push_back(exp_data_q[k]); want_i.push_back(exp_idx_q[k]); end
    n = obs_data_q.size() - base;
    checks++; if (n != want_d.size()) begin errors++; $display("[TB] FAIL t5_nvalid got %0d want %0d", n, want_d.size()); end
    for (int k = 0; k < n && k < want_d.size(); k++) begin
      checks++;
      if (obs_data_q[base+k] !== want_d[k] || obs_idx_q[base+k] !== want_i[k]) begin
        errors++; $display("[TB] FAIL t5_byte[%0d] got %h/%0d want %h/%0d", k, obs_data_q[base+k], obs_idx_q[base+k], want_d[k], want_i[k]);
      end
    end
    checks++; if (stop_cnt - sbase != 1) begin errors++; $display("[TB] FAIL t5_stop got %0d want 1", stop_cnt - sbase); end
  endtask

  task automatic test_saturation();
    int base, sbase, n;
    tx_q.delete();
    for (int i = 0; i < 17; i++) tx_q.push_back(8'($urandom_range(0, 255)));
    model_txn(8'h34);
    base = obs_data_q.size(); sbase = stop_cnt;
    drive_txn(8'h34);
    foreach (exp_ack_q[k]) begin
      checks++; if (ack_q[k] !== exp_ack_q[k]) begin errors++; $display("[TB] FAIL t6_ack[%0d] got %b want %b", k, ack_q[k], exp_ack_q[k]); end
    end
    n = obs_data_q.size() - base;
    checks++; if (n != exp_data_q.size()) begin errors++; $display("[TB] FAIL t6_nvalid got %0d want %0d", n, exp_data_q.size()); end
    for (int k = 0; k < n && k < exp_data_q.size(); k++) begin
      checks++;
      if (obs_data_q[base+k] !== exp_data_q[k] || obs_idx_q[base+k] !== exp_idx_q[k]) begin
        errors++; $display("[TB] FAIL t6_byte[%0d] got %h/%0d want %h/%0d", k, obs_data_q[base+k], obs_idx_q[base+k], exp_data_q[k], exp_idx_q[k]);
      end
    end
    checks++; if (stop_cnt - sbase != exp_stop) begin errors++; $display("[TB] FAIL t6_stop got %0d want %0d", stop_cnt - sbase, exp_stop); end
  endtask

  task automatic test_random_txns();
    int base, sbase, n, len;
    logic [7:0] addr;
    for (int t = 0; t < 4; t++) begin
      addr = ($urandom_range(0, 1) == 1) ? 8'h34 : 8'($urandom_range(0, 255));
      len = $urandom_range(1, 4);
      tx_q.delete();
      for (int i = 0; i < len; i++) tx_q.push_back(8'($urandom_range(0, 255)));
      model_txn(addr);
      base = obs_data_q.size(); sbase = stop_cnt;
      drive_txn(addr);
      foreach (exp_ack_q[k]) begin
        checks++; if (ack_q[k] !== exp_ack_q[k]) begin errors++; $display("[TB] FAIL rnd%0d_ack[%0d] addr %h got %b want %b", t, k, addr, ack_q[k], exp_ack_q[k]); end
      end
      n = obs_data_q.size() - base;
      checks++; if (n != exp_data_q.size()) begin errors++; $display("[TB] FAIL rnd%0d_nvalid got %0d want %0d", t, n, exp_data_q.size()); end
      for (int k = 0; k < n && k < exp_data_q.size(); k++) begin
        checks++;
        if (obs_data_q[base+k] !== exp_data_q[k] || obs_idx_q[base+k] !== exp_idx_q[k]) begin
          errors++; $display("[TB] FAIL rnd%0d_byte[%0d] got %h/%0d want %h/%0d", t, k, obs_data_q[base+k], obs_idx_q[base+k], exp_data_q[k], exp_idx_q[k]);
        end
      end
      checks++; if (stop_cnt - sbase != exp_stop) begin errors++; $display("[TB] FAIL rnd%0d_stop got %0d want %0d", t, stop_cnt - sbase, exp_stop); end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_wrong_addr();
    test_read();
    test_repeated_start();
    test_reset_mid();
    test_saturation();
    test_random_txns();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
